flit_arb_requester: RTL and testbench

//  Agent-side counterpart of a router round-robin arbiter: one instance per input port.

---
 rtl/flit_arb_requester.sv | 242 ++++++++++++++++++++++++
 tb/tb_flit_arb_requester.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_arb_requester.sv
// rtl/flit_arb_requester.sv - per-port flit buffer and round-robin arbiter requester
// Optional feature: define FLIT_ARB_REQUESTER_STARVATION_EN to enable the starvation counter behind starve_o.

// Input flit queue: circular buffer, pointers wrap at DEPTH-1, no bypass path.
module flit_arb_requester_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             not_empty_o,
   output logic             not_full_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign not_empty_o = (count_q != '0);
   assign not_full_o  = (count_q < CNT_FULL);
   assign head_o      = mem_q[rd_ptr_q];
   assign do_push     = push_i & not_full_o;
   assign do_pop      = pop_i & not_empty_o;

   // Next pointer/count values; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end
endmodule

// Requester: buffers flits, requests the arbiter, sends on grant, owns the output for a whole packet.
module flit_arb_requester #(
   parameter int FLIT_WIDTH         = 32,
   parameter int BUFFER_DEPTH       = 4,
   parameter int DOWNSTREAM_CREDITS = 4,
   parameter int STARVE_LIMIT       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flit_valid_i,
   input  logic [FLIT_WIDTH-1:0] flit_i,
   output logic                  flit_ready_o,
   output logic                  request_o,
   input  logic                  grant_i,
   output logic                  lock_o,
   output logic                  out_valid_o,
   output logic [FLIT_WIDTH-1:0] out_flit_o,
   input  logic                  credit_i,
   output logic                  error_o,
   output logic                  starve_o
);
   localparam int CRED_W = $clog2(DOWNSTREAM_CREDITS + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DOWNSTREAM_CREDITS);

   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CRED_W-1:0]       credits_q, credits_d;
   logic                    out_valid_q, out_valid_d;
   logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
   logic                    error_q, error_d;

   logic [FLIT_WIDTH-1:0]   fifo_head;
   logic                    fifo_not_empty;
   logic                    fifo_not_full;
   logic                    fifo_pop;
   logic [1:0]              head_type;
   logic                    head_is_start;
   logic                    send;
   logic                    drop;
   logic                    bad_start;

   flit_arb_requester_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (flit_valid_i),
      .data_i      (flit_i),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .not_empty_o (fifo_not_empty),
      .not_full_o  (fifo_not_full)
   );

   // Head and head+tail both have the low type bit set: they may open a packet.
   assign head_type     = fifo_head[FLIT_WIDTH-1 -: 2];
   assign head_is_start = head_type[0];

   assign flit_ready_o = fifo_not_full;
   assign request_o    = fifo_not_empty & (credits_q != '0) & (head_is_start | (state_q == ACTIVE));
   assign send         = request_o & grant_i;
   // A body/tail with no open packet can never be sent; discard it without touching credits.
   assign drop         = (state_q == IDLE) & fifo_not_empty & ~head_is_start;
   // A new head arriving inside a packet closes the current one as a tail.
   assign bad_start    = send & (state_q == ACTIVE) & head_is_start;
   assign fifo_pop     = send | drop;

   assign lock_o      = (state_q == ACTIVE);
   assign out_valid_o = out_valid_q;
   assign out_flit_o  = out_flit_q;
   assign error_o     = error_q;

   // Next packet state, output flit, credit count and protocol-error pulse.
   always_comb begin
      state_d     = state_q;
      credits_d   = credits_q;
      out_valid_d = send;
      out_flit_d  = out_flit_q;
      error_d     = 1'b0;

      if (send) begin
         out_flit_d = fifo_head;
         if (state_q == IDLE) begin
            if (head_type == TYPE_HEAD) begin
               state_d = ACTIVE;
            end
         end else if (head_is_start) begin
            out_flit_d[FLIT_WIDTH-1 -: 2] = TYPE_TAIL;
            state_d = IDLE;
         end else if (head_type == TYPE_TAIL) begin
            state_d = IDLE;
         end
      end

      case ({credit_i, send})
         2'b10: begin
            if (credits_q != CRED_MAX) begin
               credits_d = credits_q + CRED_W'(1);
            end
         end
         2'b01:   credits_d = credits_q - CRED_W'(1);
         default: credits_d = credits_q;
      endcase

      error_d = drop
              | bad_start
              | (grant_i & ~request_o)
              | (credit_i & ~send & (credits_q == CRED_MAX));
   end

   // Packet FSM with its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         credits_q   <= CRED_MAX;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         credits_q   <= credits_d;
         out_valid_q <= out_valid_d;
         out_flit_q  <= out_flit_d;
         error_q     <= error_d;
      end
   end

`ifdef FLIT_ARB_REQUESTER_STARVATION_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                starve_q, starve_d;

   // Count consecutive unanswered request cycles, saturating at the limit.
   always_comb begin
      wait_cnt_d = '0;
      if (request_o & ~grant_i) begin
         wait_cnt_d = (wait_cnt_q == STARVE_MAX) ? wait_cnt_q : wait_cnt_q + STARVE_W'(1);
      end
      starve_d = (wait_cnt_d == STARVE_MAX);
   end

   // Wait counter and registered starvation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         starve_q   <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         starve_q   <= starve_d;
      end
   end

   assign starve_o = starve_q;
`else
   // Feature disabled: no counter; the limit is only referenced to keep the parameter set uniform.
   assign starve_o = 1'b0 & (STARVE_LIMIT > 0);
`endif
endmodule

// File: tb/tb_flit_arb_requester.sv
// tb/tb_flit_arb_requester.sv - self-checking bench for flit_arb_requester
module tb_flit_arb_requester;
   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_HT   = 2'b11;
`ifdef FLIT_ARB_REQUESTER_STARVATION_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flit_valid_i = 1'b0;
   logic [31:0] flit_i = '0;
   logic        flit_ready_o, request_o, grant_i = 1'b0, lock_o, out_valid_o;
   logic [31:0] out_flit_o;
   logic        credit_i = 1'b0, error_o, starve_o;

   logic        c2_valid = 1'b0;
   logic [31:0] c2_flit = '0;
   logic        c2_ready, c2_req, c2_grant = 1'b0, c2_lock, c2_ov;
   logic [31:0] c2_oflit;
   logic        c2_credit = 1'b0, c2_err, c2_starve;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   flit_arb_requester u_dut (
      .clk(clk), .rst(rst), .flit_valid_i(flit_valid_i), .flit_i(flit_i),
      .flit_ready_o(flit_ready_o), .request_o(request_o), .grant_i(grant_i),
      .lock_o(lock_o), .out_valid_o(out_valid_o), .out_flit_o(out_flit_o),
      .credit_i(credit_i), .error_o(error_o), .starve_o(starve_o)
   );

   flit_arb_requester #(.DOWNSTREAM_CREDITS(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .flit_valid_i(c2_valid), .flit_i(c2_flit),
      .flit_ready_o(c2_ready), .request_o(c2_req), .grant_i(c2_grant),
      .lock_o(c2_lock), .out_valid_o(c2_ov), .out_flit_o(c2_oflit),
      .credit_i(c2_credit), .error_o(c2_err), .starve_o(c2_starve)
   );

   typedef struct {
      logic        valid;
      logic [31:0] flit;
      logic        grant;
      logic        credit;
      logic        e_ready;
      logic        e_req;
      logic        e_lock;
      logic        e_ov;
      logic [31:0] e_flit;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic v, logic [31:0] f, logic g, logic c,
                               logic rdy, logic rq, logic lk, logic ov, logic [31:0] of, logic er);
      vec_t t;
      t.valid = v; t.flit = f; t.grant = g; t.credit = c;
      t.e_ready = rdy; t.e_req = rq; t.e_lock = lk; t.e_ov = ov; t.e_flit = of; t.e_err = er;
      return t;
   endfunction

   task automatic drive(input logic v, input logic [31:0] f, input logic g, input logic c);
      flit_valid_i = v; flit_i = f; grant_i = g; credit_i = c;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      c2_valid = 1'b0; c2_flit = '0; c2_grant = 1'b0; c2_credit = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Directed packet/error table.
   task automatic run_table();
      logic [31:0] h, b1, b2, tl, ht, bad, h3, h4, h4t;
      h = 32'h4000_00A0; b1 = 32'h0000_00B1; b2 = 32'h0000_00B2; tl = 32'h8000_00CF;
      ht = 32'hC000_0001; bad = 32'h0000_0BAD; h3 = 32'h4000_1111; h4 = 32'h4000_2222;
      h4t = 32'h8000_2222;
      vecs.delete();
      vecs.push_back(mk(1, h,   0, 0,  1, 0, 0, 0, 32'h0, 0));
      vecs.push_back(mk(1, b1,  1, 0,  1, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(1, b2,  1, 0,  1, 1, 1, 1, h,     0));
      vecs.push_back(mk(1, tl,  1, 0,  1, 1, 1, 1, b1,    0));
      vecs.push_back(mk(0, '0,  1, 0,  1, 1, 1, 1, b2,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 1, tl,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  0, 0,  1, 0, 0, 0, tl,    1));
      vecs.push_back(mk(1, ht,  0, 0,  1, 0, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  1, 0,  1, 1, 0, 0, tl,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 1, ht,    0));
      vecs.push_back(mk(1, bad, 0, 0,  1, 0, 0, 0, ht,    0));
      vecs.push_back(mk(0, '0,  0, 0,  1, 0, 0, 0, ht,    0));
      vecs.push_back(mk(0, '0,  0, 0,  1, 0, 0, 0, ht,    1));
      vecs.push_back(mk(0, '0,  1, 0,  1, 0, 0, 0, ht,    0));
      vecs.push_back(mk(0, '0,  0, 0,  1, 0, 0, 0, ht,    1));
      vecs.push_back(mk(1, h3,  0, 0,  1, 0, 0, 0, ht,    0));
      vecs.push_back(mk(1, h4,  1, 0,  1, 1, 0, 0, ht,    0));
      vecs.push_back(mk(0, '0,  1, 0,  1, 1, 1, 1, h3,    0));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 1, h4t,   1));
      vecs.push_back(mk(0, '0,  0, 1,  1, 0, 0, 0, h4t,   0));
      vecs.push_back(mk(0, '0,  0, 0,  1, 0, 0, 0, h4t,   0));
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].flit, vecs[i].grant, vecs[i].credit);
         #1;
         check($sformatf("table[%0d] rdy,req,lock,ov,err,flit", i),
               {flit_ready_o, request_o, lock_o, out_valid_o, error_o, out_flit_o},
               {vecs[i].e_ready, vecs[i].e_req, vecs[i].e_lock, vecs[i].e_ov, vecs[i].e_err, vecs[i].e_flit});
      end
   endtask

   // Two-credit instance: requests stop when credits run out, one returned credit releases one flit.
   task automatic run_credits2();
      logic [31:0] pkt [4];
      pkt[0] = 32'h4000_0001; pkt[1] = 32'h0000_0002; pkt[2] = 32'h0000_0003; pkt[3] = 32'h8000_0004;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c2_valid = 1'b1; c2_flit = pkt[i]; c2_grant = 1'b0;
      end
      @(negedge clk); c2_valid = 1'b0; c2_grant = 1'b1; #1;
      check("c2_req_first", c2_req, 1'b1);
      @(negedge clk); #1;
      check("c2_second_send", {c2_req, c2_ov, c2_oflit}, {1'b1, 1'b1, pkt[0]});
      @(negedge clk); c2_grant = 1'b0; #1;
      check("c2_req_drop_lock", {c2_req, c2_lock, c2_ov, c2_oflit}, {1'b0, 1'b1, 1'b1, pkt[1]});
      @(negedge clk); c2_credit = 1'b1; #1;
      check("c2_req_still_low", {c2_req, c2_ov}, {1'b0, 1'b0});
      @(negedge clk); c2_credit = 1'b0; c2_grant = 1'b1; #1;
      check("c2_req_after_credit", c2_req, 1'b1);
      @(negedge clk); c2_grant = 1'b0; #1;
      check("c2_third_send", {c2_req, c2_lock, c2_ov, c2_oflit}, {1'b0, 1'b1, 1'b1, pkt[2]});
      @(negedge clk); #1;
      check("c2_no_fourth", {c2_ov, c2_lock}, {1'b0, 1'b1});
   endtask

   // Fill to full, no bypass during pop, then pointer wrap with ordered delivery.
   task automatic run_fill_wrap();
      logic [31:0] exp_q[$];
      int pushed;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(1'b1, 32'hC000_0010 + i, 1'b0, 1'b0); #1;
         check($sformatf("fill_ready[%0d]", i), flit_ready_o, 1'b1);
         exp_q.push_back(32'hC000_0010 + i);
      end
      @(negedge clk); drive(1'b1, 32'hC000_0099, 1'b1, 1'b0); #1;
      check("full_no_bypass", {flit_ready_o, request_o}, {1'b0, 1'b1});
      @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0); #1;
      check("ready_after_pop", {flit_ready_o, out_valid_o, out_flit_o}, {1'b1, 1'b1, exp_q.pop_front()});
      for (int i = 0; i < 10; i++) exp_q.push_back(32'hC000_0020 + i);
      pushed = 0;
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         drive(pushed < 10, 32'hC000_0020 + pushed, 1'b1, out_valid_o);
         #1;
         if (out_valid_o) check("wrap_order", out_flit_o, exp_q.pop_front());
         if (flit_valid_i && flit_ready_o) pushed++;
      end
      check("wrap_all_received", exp_q.size(), 0);
   endtask

   // Starvation threshold, clear on grant, then reset in the middle of a packet.
   task automatic run_starve_and_reset();
      @(negedge clk); drive(1'b1, 32'hC000_0077, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0); #1;
         if (k == 1) check("starve_req_up", request_o, 1'b1);
         if (k == 16) check("starve_before_limit", starve_o, 1'b0);
      end
      @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0); #1;
      check("starve_at_limit", starve_o, STARVE_EN);
      @(negedge clk); drive(1'b1, 32'h4000_0055, 1'b0, 1'b0); #1;
      check("starve_clear_after_grant", {starve_o, out_valid_o}, {1'b0, 1'b1});
      @(negedge clk); drive(1'b1, 32'h0000_0056, 1'b1, 1'b0);
      @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0); #1;
      check("mid_pkt_lock", lock_o, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("async_reset_outputs",
            {flit_ready_o, request_o, lock_o, out_valid_o, error_o, starve_o, out_flit_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      @(negedge clk); rst = 1'b0;
      @(negedge clk); #1;
      check("no_tail_after_reset", {flit_ready_o, request_o, lock_o, out_valid_o},
            {1'b1, 1'b0, 1'b0, 1'b0});
   endtask

   // Random traffic against a queue-based model of the spec rules.
   task automatic run_random();
      logic [31:0] mq[$];
      bit m_active = 0, m_ov = 0, m_err = 0, m_starve = 0, gen_in_pkt = 0;
      int m_cred = 4, m_wait = 0;
      logic [31:0] m_flit = '0, f;
      logic [1:0] t, tp;
      bit m_ready, m_req, send, drop, n_err;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(0, 3));
         else if (!gen_in_pkt) t = ($urandom_range(0, 3) == 0) ? T_HT : T_HEAD;
         else t = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
         drive($urandom_range(0, 2) != 0, {t, 30'($urandom)}, $urandom_range(0, 3) != 0,
               (m_cred < 4) && ($urandom_range(0, 2) == 0));
         #1;
         m_ready = mq.size() < 4;
         tp = (mq.size() > 0) ? mq[0][31:30] : T_BODY;
         m_req = (mq.size() > 0) && (m_cred > 0) && (tp == T_HEAD || tp == T_HT || m_active);
         check($sformatf("rand[%0d] rdy,req,lock,ov,err,stv,flit", c),
               {flit_ready_o, request_o, lock_o, out_valid_o, error_o, starve_o, out_flit_o},
               {m_ready, m_req, m_active, m_ov, m_err, m_starve, m_flit});
         send = m_req && grant_i;
         drop = !m_active && (mq.size() > 0) && (tp == T_BODY || tp == T_TAIL);
         n_err = drop || (send && m_active && (tp == T_HEAD || tp == T_HT))
              || (grant_i && !m_req) || (credit_i && !send && m_cred == 4);
         if (send) begin
            f = mq.pop_front();
            if (m_active && (tp == T_HEAD || tp == T_HT)) begin
               f[31:30] = T_TAIL;
               m_active = 0;
            end else if (!m_active && tp == T_HEAD) m_active = 1;
            else if (m_active && tp == T_TAIL) m_active = 0;
            m_flit = f;
         end else if (drop) begin
            void'(mq.pop_front());
         end
         if (send && !credit_i) m_cred--;
         else if (!send && credit_i && m_cred < 4) m_cred++;
         if (flit_valid_i && m_ready) begin
            mq.push_back(flit_i);
            if (t == T_HEAD) gen_in_pkt = 1;
            else if (t == T_TAIL || t == T_HT) gen_in_pkt = 0;
         end
         if (STARVE_EN && m_req && !grant_i) m_wait = (m_wait < 16) ? m_wait + 1 : 16;
         else m_wait = 0;
         m_starve = (m_wait == 16);
         m_ov = send;
         m_err = n_err;
      end
   endtask

   initial begin
      do_reset();
      #1;
      check("reset_main", {flit_ready_o, request_o, lock_o, out_valid_o, error_o, starve_o, out_flit_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      check("reset_c2", {c2_ready, c2_req, c2_lock, c2_ov, c2_err, c2_starve, c2_oflit},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      run_credits2();
      do_reset();
      run_table();
      do_reset();
      run_fill_wrap();
      do_reset();
      run_starve_and_reset();
      do_reset();
      run_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
